hazard_stall_unit: RTL



---
 rtl/hazard_stall_unit_if.sv | 42 ++++
 rtl/hazard_stall_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit_if.sv
// Pipeline-side bundle of the hazard/stall unit: ID/EX/MEM register fields
// and cache stall inputs in, pipeline-register enables and bubble/branch
// stall controls out. master = pipeline side, slave = hazard_stall_unit.
interface hazard_stall_unit_if;
    logic [4:0] ID_rs1_i;
    logic [4:0] ID_rs2_i;
    logic [6:0] ID_opcode_i;
    logic [4:0] ID_EX_rd_i;
    logic [6:0] ID_EX_opcode_i;
    logic       EX_load_regfile_i;
    logic [4:0] EX_MEM_rd_i;
    logic [6:0] EX_MEM_opcode_i;
    logic       MEM_load_regfile_i;
    logic       imem_stall_i;
    logic       dmem_stall_i;
    logic       load_pc_o;
    logic       load_if_id_o;
    logic       load_id_ex_o;
    logic       load_ex_mem_o;
    logic       load_mem_wb_o;
    logic       ID_HD_controlmux_sel_o;
    logic       stall_br_haz1_o;
    logic       stall_br_haz2_o;

    modport master (
        output ID_rs1_i, ID_rs2_i, ID_opcode_i, ID_EX_rd_i, ID_EX_opcode_i,
               EX_load_regfile_i, EX_MEM_rd_i, EX_MEM_opcode_i,
               MEM_load_regfile_i, imem_stall_i, dmem_stall_i,
        input  load_pc_o, load_if_id_o, load_id_ex_o, load_ex_mem_o,
               load_mem_wb_o, ID_HD_controlmux_sel_o, stall_br_haz1_o,
               stall_br_haz2_o
    );

    modport slave (
        input  ID_rs1_i, ID_rs2_i, ID_opcode_i, ID_EX_rd_i, ID_EX_opcode_i,
               EX_load_regfile_i, EX_MEM_rd_i, EX_MEM_opcode_i,
               MEM_load_regfile_i, imem_stall_i, dmem_stall_i,
        output load_pc_o, load_if_id_o, load_id_ex_o, load_ex_mem_o,
               load_mem_wb_o, ID_HD_controlmux_sel_o, stall_br_haz1_o,
               stall_br_haz2_o
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Hazard / stall unit: detects load-use and decode-stage branch operand
// hazards, inserts ID/EX bubbles, gates pipeline-register enables and
// freezes the pipeline while either cache stalls.
// Optional build macro HAZARD_PERF_CNT_EN adds three saturating
// performance counters (load-use stalls, branch stalls, freeze cycles).
//
// state | meaning
// RUN   | normal issue; hazards are detected on the ID instruction
// BR1   | second bubble of a load->branch stall; no re-detection
module hazard_stall_unit #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_stall_unit_if.slave   hsu
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] stalls_lu_o,
    output logic [CNT_WIDTH-1:0] stalls_br_o,
    output logic [CNT_WIDTH-1:0] freeze_cycles_o
`endif
);

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_REG   = 7'b0110011;

    typedef enum logic {RUN = 1'b0, BR1 = 1'b1} state_t;

    state_t state_q, state_d;

    logic freeze;
    logic uses_rs1, uses_rs2, is_br;
    logic match_ex, match_mem;
    logic lu_haz, br1_haz, br2_haz;
    logic bubble;

    // Hazard detection on the instruction currently in ID
    always_comb begin
        freeze   = hsu.imem_stall_i | hsu.dmem_stall_i;
        uses_rs2 = (hsu.ID_opcode_i == OP_BR) || (hsu.ID_opcode_i == OP_STORE) ||
                   (hsu.ID_opcode_i == OP_REG);
        uses_rs1 = !((hsu.ID_opcode_i == OP_LUI) || (hsu.ID_opcode_i == OP_AUIPC) ||
                     (hsu.ID_opcode_i == OP_JAL));
        is_br    = (hsu.ID_opcode_i == OP_BR) || (hsu.ID_opcode_i == OP_JALR);

        match_ex  = (hsu.ID_EX_rd_i != 5'd0) &&
                    ((uses_rs1 && (hsu.ID_rs1_i == hsu.ID_EX_rd_i)) ||
                     (uses_rs2 && (hsu.ID_rs2_i == hsu.ID_EX_rd_i)));
        match_mem = (hsu.EX_MEM_rd_i != 5'd0) &&
                    ((uses_rs1 && (hsu.ID_rs1_i == hsu.EX_MEM_rd_i)) ||
                     (uses_rs2 && (hsu.ID_rs2_i == hsu.EX_MEM_rd_i)));

        lu_haz  = !is_br && (hsu.ID_EX_opcode_i == OP_LOAD) && match_ex;
        br2_haz =  is_br && (hsu.ID_EX_opcode_i == OP_LOAD) && match_ex;
        // A load still in MEM only blocks a branch; ALU results in MEM are
        // already forwardable into decode.
        br1_haz =  is_br && !br2_haz &&
                   ((hsu.EX_load_regfile_i && match_ex) ||
                    ((hsu.EX_MEM_opcode_i == OP_LOAD) && hsu.MEM_load_regfile_i &&
                     match_mem));
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    // Next-state logic; a frozen pipeline holds its stall position
    always_comb begin
        state_d = state_q;
        if (!freeze) begin
            case (state_q)
                RUN:     if (br2_haz) state_d = BR1;
                BR1:     state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    // Output logic: bubble decision, then freeze and reset overrides
    always_comb begin
        bubble                     = 1'b0;
        hsu.stall_br_haz1_o        = 1'b0;
        hsu.stall_br_haz2_o        = 1'b0;
        hsu.load_pc_o              = 1'b1;
        hsu.load_if_id_o           = 1'b1;
        hsu.load_id_ex_o           = 1'b1;
        hsu.load_ex_mem_o          = 1'b1;
        hsu.load_mem_wb_o          = 1'b1;
        hsu.ID_HD_controlmux_sel_o = 1'b0;

        case (state_q)
            RUN: begin
                if (br2_haz) begin
                    bubble              = 1'b1;
                    hsu.stall_br_haz2_o = 1'b1;
                end else if (lu_haz || br1_haz) begin
                    bubble              = 1'b1;
                    hsu.stall_br_haz1_o = br1_haz;
                end
            end
            BR1: begin
                bubble              = 1'b1;
                hsu.stall_br_haz1_o = 1'b1;
            end
            default: ;
        endcase

        if (bubble) begin
            hsu.load_pc_o              = 1'b0;
            hsu.load_if_id_o           = 1'b0;
            hsu.ID_HD_controlmux_sel_o = 1'b1;
        end

        // Stall flags survive a freeze so forwarding stays suppressed.
        if (freeze) begin
            hsu.load_pc_o              = 1'b0;
            hsu.load_if_id_o           = 1'b0;
            hsu.load_id_ex_o           = 1'b0;
            hsu.load_ex_mem_o          = 1'b0;
            hsu.load_mem_wb_o          = 1'b0;
            hsu.ID_HD_controlmux_sel_o = 1'b0;
        end

        if (rst) begin
            hsu.load_pc_o              = 1'b0;
            hsu.load_if_id_o           = 1'b0;
            hsu.load_id_ex_o           = 1'b0;
            hsu.load_ex_mem_o          = 1'b0;
            hsu.load_mem_wb_o          = 1'b0;
            hsu.ID_HD_controlmux_sel_o = 1'b0;
            hsu.stall_br_haz1_o        = 1'b0;
            hsu.stall_br_haz2_o        = 1'b0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [CNT_WIDTH-1:0] stalls_lu_q, stalls_lu_d;
    logic [CNT_WIDTH-1:0] stalls_br_q, stalls_br_d;
    logic [CNT_WIDTH-1:0] freeze_cycles_q, freeze_cycles_d;
    logic                 inc_lu, inc_br;

    // Saturating event counters; frozen bubbles are not counted as stalls
    always_comb begin
        inc_lu = !freeze && (state_q == RUN) && lu_haz;
        inc_br = !freeze && ((state_q == BR1) || ((state_q == RUN) && (br1_haz || br2_haz)));

        stalls_lu_d     = stalls_lu_q;
        stalls_br_d     = stalls_br_q;
        freeze_cycles_d = freeze_cycles_q;
        if (inc_lu && (stalls_lu_q != CNT_MAX))         stalls_lu_d     = stalls_lu_q + CNT_ONE;
        if (inc_br && (stalls_br_q != CNT_MAX))         stalls_br_d     = stalls_br_q + CNT_ONE;
        if (freeze && (freeze_cycles_q != CNT_MAX))     freeze_cycles_d = freeze_cycles_q + CNT_ONE;
    end

    // Counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stalls_lu_q     <= '0;
            stalls_br_q     <= '0;
            freeze_cycles_q <= '0;
        end else begin
            stalls_lu_q     <= stalls_lu_d;
            stalls_br_q     <= stalls_br_d;
            freeze_cycles_q <= freeze_cycles_d;
        end
    end

    assign stalls_lu_o     = stalls_lu_q;
    assign stalls_br_o     = stalls_br_q;
    assign freeze_cycles_o = freeze_cycles_q;
`else
    // Counters compiled out; the width parameter stays so instantiations
    // are identical in both builds.
    if (CNT_WIDTH < 1) begin : g_cnt_width_unused
    end
`endif

endmodule
